// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one external request/acknowledge memory port between instruction
//   fetch and MEM-stage data access. One transaction is in flight at a time.
//   When both sides request, DATA wins unless the last completed grant was
//   DATA; in that case fetch goes first so it is never starved. The block
//   returns fetched and loaded words, raises the pipeline stalls, and aborts a
//   transaction after TIMEOUT cycles without an ack. An abort sets a sticky
//   error flag.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           fetch request and pc
//   if_inst/if_valid         last fetched word; 1-cycle "new word" pulse
//   d_req/d_write/d_addr/d_wdata   data request (store when d_write=1)
//   d_rdata/d_valid          last loaded word; 1-cycle completion pulse
//   bus_req/bus_we/bus_addr/bus_wdata   external request, held until done
//   bus_rdata/bus_ack        external read data and completion
//   stall_pipe/stall_fetch   pipeline freeze controls
//   bus_err                  sticky timeout flag
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_pipe,
    output logic        stall_fetch,
    output logic        bus_err
);
    typedef enum logic [1:0] {S_IDLE, S_INST, S_DATA} state_t;

    localparam logic [7:0] TO8 = 8'(TIMEOUT);

    state_t      state_q;
    logic        last_data_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] if_inst_q, d_rdata_q, bus_addr_q, bus_wdata_q;
    logic        if_valid_q, d_valid_q, bus_req_q, bus_we_q, bus_err_q;

    logic        elig_i, elig_d, pick_i, pick_d;
    logic        timeout, done;
    logic [31:0] rdata_eff;

    // A requester whose valid pulse is high this cycle has just been served;
    // its req is still up only because it has not seen the pulse yet.
    assign elig_i = if_req & ~if_valid_q;
    assign elig_d = d_req  & ~d_valid_q;
    assign pick_d = elig_d & (~elig_i | ~last_data_q);
    assign pick_i = elig_i & ~pick_d;

    // The counter holds (bus cycle - 1), so the abort fires at the end of
    // bus cycle TIMEOUT. A real ack in that same cycle takes precedence.
    assign cnt_d     = cnt_q + 8'd1;
    assign timeout   = ~bus_ack & (cnt_d == TO8);
    assign done      = bus_ack | timeout;
    assign rdata_eff = bus_ack ? bus_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_data_q <= 1'b0;
            cnt_q       <= 8'd0;
            if_inst_q   <= 32'h0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= 32'h0;
            d_valid_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_d) begin
                        state_q     <= S_DATA;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= d_write;
                        bus_addr_q  <= d_addr;
                        bus_wdata_q <= d_wdata;
                        cnt_q       <= 8'd0;
                    end else if (pick_i) begin
                        state_q     <= S_INST;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= if_addr;
                        bus_wdata_q <= 32'h0;
                        cnt_q       <= 8'd0;
                    end
                end
                S_INST, S_DATA: begin
                    if (done) begin
                        state_q     <= S_IDLE;
                        bus_req_q   <= 1'b0;
                        cnt_q       <= 8'd0;
                        last_data_q <= (state_q == S_DATA);
                        if (!bus_ack)
                            bus_err_q <= 1'b1;
                        if (state_q == S_INST) begin
                            if_inst_q  <= rdata_eff;
                            if_valid_q <= 1'b1;
                        end else begin
                            d_valid_q <= 1'b1;
                            if (!bus_we_q)
                                d_rdata_q <= rdata_eff;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_inst     = if_inst_q;
    assign if_valid    = if_valid_q;
    assign d_rdata     = d_rdata_q;
    assign d_valid     = d_valid_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_err     = bus_err_q;

    assign stall_pipe  = d_req & ~d_valid_q;
    assign stall_fetch = (if_req & ~if_valid_q) | stall_pipe;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter and sequencer that shares one external memory port between the pipelined datapath's instruction fetch (IAD/IDT side) and its MEM-stage data access (DAD/DDT side, driven by `mreq_M`/`WRITE`). It grants one transaction at a time over a request/acknowledge bus with variable wait states. It returns fetched instructions and loaded data to the datapath. It generates the stall signals that freeze the pipeline while an access is outstanding, and flags bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, 255: bus cycles without `bus_ack` before a transaction is aborted (1..255).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch requests the instruction at `if_addr`.
- `if_addr` in 32: fetch address (pc).
- `if_inst` out 32: last fetched instruction, held until the next fetch completes.
- `if_valid` out 1: one-cycle pulse; `if_inst` is new.
- `d_req` in 1: data access request (`mreq_M`).
- `d_write` in 1: 1 = store, 0 = load (`WRITE`).
- `d_addr` in 32: data address (`alu_out_forMem`).
- `d_wdata` in 32: store data (`rd2_forMem`).
- `d_rdata` out 32: load data, held until the next data completion.
- `d_valid` out 1: one-cycle pulse; the data access is complete (load or store).
- `bus_req` out 1: external transaction active.
- `bus_we` out 1: external write enable.
- `bus_addr` out 32: external address.
- `bus_wdata` out 32: external write data.
- `bus_rdata` in 32: external read data, valid with `bus_ack`.
- `bus_ack` in 1: external completion, sampled only while `bus_req`=1.
- `stall_pipe` out 1: freeze all pipeline registers and pc.
- `stall_fetch` out 1: freeze pc and the IF/ID register.
- `bus_err` out 1: sticky timeout flag.

## Operation
- The FSM has three states:
  - IDLE: no bus activity.
  - INST: fetch transaction on the bus.
  - DATA: data transaction on the bus.
- Arbitration happens only in IDLE, on the rising edge:
  - A request whose own valid pulse is asserted in that same cycle is ignored, because it has already been served.
  - If both are eligible: DATA wins, unless the previous completed grant was DATA (`last_data`=1), in which case INST wins. This alternation prevents fetch starvation.
  - If only one is eligible, it is granted.
  - If neither is eligible, the FSM stays in IDLE.
- On grant:
  - `bus_addr`, `bus_we`, and `bus_wdata` are registered from the winner. INST always uses `we`=0 and `wdata`=0.
  - `bus_req` goes to 1, and all bus outputs stay stable until completion.
  - The wait counter clears to 0.
- In INST/DATA, each cycle without `bus_ack` increments the wait counter (8-bit).
- Completion on `bus_ack`=1:
  - INST: `bus_rdata` is captured into `if_inst`.
  - DATA load: `bus_rdata` is captured into `d_rdata`.
  - DATA store: `d_rdata` is left unchanged.
  - The corresponding valid pulses for the next cycle, `last_data` updates, and the FSM returns to IDLE.
- Timeout: if the counter reaches `TIMEOUT` with no ack, the transaction completes as if acked, with read data forced to 32'h0. `bus_err` is set and stays at 1 until reset.
- A `bus_ack` arriving in IDLE is ignored.
- `stall_pipe` = `d_req` & ~`d_valid`.
- `stall_fetch` = (`if_req` & ~`if_valid`) | `stall_pipe`.
- Requesters must hold `req` and operands stable until their valid pulse. Changes while a transaction is in progress are not tracked.

## Timing
- Reset (asynchronous, `rst`=0): state=IDLE, `last_data`=0, counter=0, and every output is 0, including `if_inst`, `d_rdata`, the bus outputs, and `bus_err`. The stall outputs follow their combinational equations, which evaluate to 0 while the valids are 0 and the inputs are low.
- `bus_req` drops in the same instant reset asserts. An aborted transaction produces no valid pulse.
- Latency: a request sampled in IDLE at edge T gives `bus_req`=1 from T. If `bus_ack` first arrives in the k-th bus cycle (k≥1), the valid pulse is in bus cycle k+1 and the FSM is in IDLE in that cycle. The minimum request-to-valid latency is 2 cycles.
- A back-to-back grant to the other requester can occur at the edge ending the valid cycle. Bus idle gap is 1 cycle.
- Timeout: the valid pulse falls TIMEOUT+1 cycles after grant, and `bus_err` rises in the same cycle as that valid.

## Test plan
- Reset, then an `if_req` at address 0x10000, with `bus_ack` in the 1st bus cycle and rdata 0x00500093. Required: `bus_addr`=0x10000, `bus_we`=0; `if_valid` pulses 1 cycle with `if_inst`=0x00500093; `stall_fetch`=1 until that pulse.
- A load at `d_addr` 0x200, with the ack in the 3rd bus cycle and rdata 0xDEADBEEF. Required: `stall_pipe`=1 for 4 cycles; `d_valid` arrives 4 cycles after grant; `d_rdata`=0xDEADBEEF.
- `if_req` and `d_req` (store of 0x55 to 0x300) asserted simultaneously from reset. Required: DATA granted first with `bus_we`=1 and `bus_wdata`=0x55, then INST. Next, with both requesting again after that INST grant: DATA granted. When both request immediately after a DATA completion: INST granted.
- `TIMEOUT`=4 with no ack. Required: valid pulses 5 cycles after grant; read data is 0; `bus_err`=1 and stays at 1 through later successful transfers.
- `rst` pulsed low mid-DATA. Required: `bus_req`=0 immediately; no `d_valid`; all outputs 0; after release, a pending `d_req` is re-granted normally.
- `bus_ack` held at 1 while IDLE with no requests. Required: no valid pulse and no state change.
